rom_stream_reader: RTL and testbench

Streaming read engine that sits in front of the single-port ROM and drains a contiguous address range onto a valid/ready output stream. It drives the ROM address bus and tracks the ROM's fixed read latency of 1 or 2 cycles, chosen by OUTPUT_REG. An internal credit-controlled buffer absorbs downstream back-pressure, so no ROM word is ever lost or duplicated. Typical uses are table playback and block transfer of ROM contents into downstream logic.

---
 rtl/rom_rd_pkg.sv | 20 ++
 rtl/rom_rd_fifo.sv | 51 +++++
 rtl/rom_stream_reader.sv | 169 ++++++++++++++++
 tb/tb_rom_stream_reader.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_rd_pkg.sv
// Shared types and constants for the ROM stream reader: FSM states, buffer
// depth and the mapping from the ROM's OUTPUT_REG setting to read latency.
package rom_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

    // A registered ROM output adds one cycle on top of the array read.
    function automatic int lat_of(input string output_reg);
        return (output_reg == "TRUE") ? 2 : 1;
    endfunction

endpackage

// File: rtl/rom_rd_fifo.sv
// Small synchronous FIFO holding {last, data} words returned by the ROM,
// with an occupancy count used by the reader's credit logic.
module rom_rd_fifo
    import rom_rd_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && (occ != OCC_W'(FIFO_DEPTH));
    assign do_rd   = rd_en && (occ != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Drains a contiguous ROM address range onto a valid/ready stream, tracking
// the ROM read latency. Define ROM_RD_LOOP_EN to honour the loop replay input.
//
// state | meaning
// IDLE  | waiting for start; zero-length start just pulses done
// ISSUE | issuing one ROM read per cycle while buffer credit allows
// DRAIN | all reads issued; waiting for the buffer to empty
module rom_stream_reader
    import rom_rd_pkg::*;
#(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 8,
    parameter string OUTPUT_REG = "FALSE"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  loop,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int LAT = lat_of(OUTPUT_REG);
    localparam int CW  = ADDR_WIDTH + 1;

    rd_state_e             state;
    rd_state_e             state_nxt;
    logic                  done_q;
    logic                  done_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] start_q;
    logic [CW-1:0]         rem_q;
    logic [CW-1:0]         len_q;
    logic [LAT-1:0]        vld_q;
    logic [LAT-1:0]        lst_q;
    int                    inflight;

    logic                  credit_ok;
    logic                  issue;
    logic                  last_issue;
    logic                  loop_en;
    logic                  accept;
    logic                  pop;

    logic [OCC_W-1:0]      fifo_occ;
    logic [DATA_WIDTH:0]   fifo_head;

`ifdef ROM_RD_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = loop & 1'b0;
`endif

    always_comb begin
        inflight = 0;
        for (int i = 0; i < LAT; i++) begin
            if (vld_q[i]) inflight = inflight + 1;
        end
    end

    // Reads already in the ROM pipeline count against buffer space.
    assign credit_ok  = (int'(fifo_occ) + inflight) < FIFO_DEPTH;
    assign issue      = (state == ISSUE) && credit_ok;
    assign last_issue = issue && (rem_q == CW'(1));
    assign accept     = (state == IDLE) && start && (length != '0);
    assign pop        = m_valid && m_ready;
    assign rom_addr   = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) state_nxt = ISSUE;
                    else              done_nxt  = 1'b1;
                end
            end
            ISSUE: begin
                if (last_issue && !loop_en) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Finish on the cycle the final buffered beat is taken.
                if ((inflight == 0) &&
                    ((fifo_occ == '0) || ((fifo_occ == OCC_W'(1)) && pop))) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = done_q;
        m_valid = (fifo_occ != '0);
        m_data  = m_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
        m_last  = m_valid & fifo_head[DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            start_q <= '0;
            rem_q   <= '0;
            len_q   <= '0;
        end else if (accept) begin
            addr_q  <= start_addr;
            start_q <= start_addr;
            rem_q   <= length;
            len_q   <= length;
        end else if (issue) begin
            if (last_issue && loop_en) begin
                addr_q <= start_q;
                rem_q  <= len_q;
            end else begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                rem_q  <= rem_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q[0] <= issue;
            lst_q[0] <= last_issue;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
        end
    end

    rom_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (vld_q[LAT-1]),
        .wr_data ({lst_q[LAT-1], rom_data}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .occ     (fifo_occ)
    );

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: one instance per ROM latency, each fed by its
// own ROM model, checked against a stream/timing model built from the rules.
module tb_rom_stream_reader;

    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          rel;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_addr = '0;
    logic [8:0]  length = '0;
    logic        loop = 1'b0;
    logic        m_ready = 1'b0;

    logic [1:0]  busy_w;
    logic [1:0]  done_w;
    logic [1:0]  m_valid_w;
    logic [1:0]  m_last_w;
    logic [7:0]  rom_addr_w [2];
    logic [15:0] rom_data_w [2];
    logic [15:0] m_data_w [2];

    logic [15:0] rom [256];
    logic [15:0] rom_pipe;

    int          cyc = 0;
    int          c0 = 0;
    logic [7:0]  sa = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    beat_t       beats0 [$];
    beat_t       beats1 [$];
    int          done_cnt [2];
    int          done_rel [2];
    int          busy_rise [2];
    int          busy_fall [2];
    int          stall_viol [2];
    int          max_out [2];
    logic        prev_stall [2];
    logic [15:0] prev_data [2];
    logic        prev_last [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_stream_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .OUTPUT_REG("FALSE")) u_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .length(length), .loop(loop), .busy(busy_w[0]), .done(done_w[0]),
        .rom_addr(rom_addr_w[0]), .rom_data(rom_data_w[0]), .m_data(m_data_w[0]),
        .m_valid(m_valid_w[0]), .m_last(m_last_w[0]), .m_ready(m_ready)
    );

    rom_stream_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .OUTPUT_REG("TRUE")) u_lat2 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .length(length), .loop(loop), .busy(busy_w[1]), .done(done_w[1]),
        .rom_addr(rom_addr_w[1]), .rom_data(rom_data_w[1]), .m_data(m_data_w[1]),
        .m_valid(m_valid_w[1]), .m_last(m_last_w[1]), .m_ready(m_ready)
    );

    // ROM models: one-cycle synchronous read, and the same with an output register.
    always @(posedge clk) begin
        rom_data_w[0] <= rom[rom_addr_w[0]];
        rom_pipe      <= rom[rom_addr_w[1]];
        rom_data_w[1] <= rom_pipe;
    end

    function automatic int nb(input int k);
        return (k == 0) ? beats0.size() : beats1.size();
    endfunction

    function automatic beat_t gb(input int k, input int i);
        if (k == 0) return beats0[i];
        return beats1[i];
    endfunction

    // Monitor: sampled mid-cycle, records handshakes and per-transfer statistics.
    always begin
        @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            int    rel;
            int    outstanding;
            beat_t b;
            rel = cyc - c0;
            if (busy_w[k]) begin
                outstanding = int'(8'(rom_addr_w[k] - sa)) - nb(k);
                if (outstanding > max_out[k]) max_out[k] = outstanding;
            end
            if (m_valid_w[k] && m_ready) begin
                b.data = m_data_w[k];
                b.last = m_last_w[k];
                b.rel  = rel;
                if (k == 0) beats0.push_back(b);
                else        beats1.push_back(b);
            end
            if (done_w[k]) begin
                done_cnt[k]++;
                if (done_rel[k] < 0) done_rel[k] = rel;
            end
            if (busy_w[k] && busy_rise[k] < 0) busy_rise[k] = rel;
            if (!busy_w[k] && busy_rise[k] >= 0 && busy_fall[k] < 0) busy_fall[k] = rel;
            if (prev_stall[k] && (!m_valid_w[k] || m_data_w[k] !== prev_data[k] ||
                                  m_last_w[k] !== prev_last[k]))
                stall_viol[k]++;
            prev_stall[k] = m_valid_w[k] && !m_ready;
            prev_data[k]  = m_data_w[k];
            prev_last[k]  = m_last_w[k];
        end
    end

    // Drives one transfer (called just after a negedge) and waits for done on both.
    // rmode: 0 ready high, 1 random with a 10-cycle low window, 2 random.
    task automatic run_xfer(input logic [7:0] a, input logic [8:0] n, input int loop_until,
                            input int rmode, input int dup_rel, output bit timed_out);
        int rel;
        beats0.delete();
        beats1.delete();
        for (int k = 0; k < 2; k++) begin
            done_cnt[k] = 0;  done_rel[k] = -1;  busy_rise[k] = -1;  busy_fall[k] = -1;
            stall_viol[k] = 0;  max_out[k] = 0;  prev_stall[k] = 1'b0;
        end
        sa = a;
        c0 = cyc;
        start = 1'b1;
        start_addr = a;
        length = n;
        loop = (loop_until > 0);
        m_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        timed_out = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            rel = cyc - c0;
            start = (rel == dup_rel);
            if (start) begin
                start_addr = a + 8'h40;
                length = 9'd7;
            end
            loop = (rel < loop_until);
            if (rmode == 0) m_ready = 1'b1;
            else if (rmode == 1 && rel >= 6 && rel < 16) m_ready = 1'b0;
            else m_ready = 1'($urandom_range(0, 1));
            if (done_cnt[0] > 0 && done_cnt[1] > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        loop = 1'b0;
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks += 6;
            if (busy_w[k] !== 1'b0)  begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", k, busy_w[k]); end
            if (done_w[k] !== 1'b0)  begin n_fail++; $display("FAIL reset_done[%0d] got %b want 0", k, done_w[k]); end
            if (m_valid_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d] got %b want 0", k, m_valid_w[k]); end
            if (m_last_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset_last[%0d] got %b want 0", k, m_last_w[k]); end
            if (m_data_w[k] !== 16'h0) begin n_fail++; $display("FAIL reset_data[%0d] got %h want 0", k, m_data_w[k]); end
            if (rom_addr_w[k] !== 8'h0) begin n_fail++; $display("FAIL reset_addr[%0d] got %h want 0", k, rom_addr_w[k]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        run_xfer(8'h10, 9'd5, 0, 0, -1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL basic_timeout got timeout want done"); end
        for (int k = 0; k < 2; k++) begin
            int lat = k + 1;
            n_checks++;
            if (nb(k) != 5) begin n_fail++; $display("FAIL basic_count[%0d] got %0d want 5", k, nb(k)); end
            for (int i = 0; i < nb(k) && i < 5; i++) begin
                beat_t b = gb(k, i);
                n_checks += 3;
                if (b.data !== rom[8'h10 + i]) begin n_fail++; $display("FAIL basic_data[%0d] beat %0d got %h want %h", k, i, b.data, rom[8'h10 + i]); end
                if (b.last !== (i == 4)) begin n_fail++; $display("FAIL basic_last[%0d] beat %0d got %b want %b", k, i, b.last, (i == 4)); end
                if (b.rel != 2 + lat + i) begin n_fail++; $display("FAIL basic_cycle[%0d] beat %0d got %0d want %0d", k, i, b.rel, 2 + lat + i); end
            end
            n_checks += 4;
            if (done_rel[k] != 2 + lat + 5) begin n_fail++; $display("FAIL basic_done_cycle[%0d] got %0d want %0d", k, done_rel[k], 2 + lat + 5); end
            if (done_cnt[k] != 1) begin n_fail++; $display("FAIL basic_done_count[%0d] got %0d want 1", k, done_cnt[k]); end
            if (busy_rise[k] != 1) begin n_fail++; $display("FAIL basic_busy_rise[%0d] got %0d want 1", k, busy_rise[k]); end
            if (busy_fall[k] != 2 + lat + 5) begin n_fail++; $display("FAIL basic_busy_fall[%0d] got %0d want %0d", k, busy_fall[k], 2 + lat + 5); end
        end
    endtask

    task automatic test_wrap();
        bit to;
        run_xfer(8'hFE, 9'd4, 0, 0, -1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL wrap_timeout got timeout want done"); end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (nb(k) != 4) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d want 4", k, nb(k)); end
            for (int i = 0; i < nb(k) && i < 4; i++) begin
                logic [7:0] ad = 8'(8'hFE + i);
                beat_t b = gb(k, i);
                n_checks += 2;
                if (b.data !== rom[ad]) begin n_fail++; $display("FAIL wrap_data[%0d] beat %0d got %h want %h", k, i, b.data, rom[ad]); end
                if (b.last !== (i == 3)) begin n_fail++; $display("FAIL wrap_last[%0d] beat %0d got %b want %b", k, i, b.last, (i == 3)); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        run_xfer(8'h30, 9'd16, 0, 1, -1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL bp_timeout got timeout want done"); end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (nb(k) != 16) begin n_fail++; $display("FAIL bp_count[%0d] got %0d want 16", k, nb(k)); end
            for (int i = 0; i < nb(k) && i < 16; i++) begin
                beat_t b = gb(k, i);
                n_checks += 2;
                if (b.data !== rom[8'h30 + i]) begin n_fail++; $display("FAIL bp_data[%0d] beat %0d got %h want %h", k, i, b.data, rom[8'h30 + i]); end
                if (b.last !== (i == 15)) begin n_fail++; $display("FAIL bp_last[%0d] beat %0d got %b want %b", k, i, b.last, (i == 15)); end
            end
            n_checks += 3;
            if (stall_viol[k] != 0) begin n_fail++; $display("FAIL bp_stall_stable[%0d] got %0d changes want 0", k, stall_viol[k]); end
            if (max_out[k] != DEPTH) begin n_fail++; $display("FAIL bp_max_outstanding[%0d] got %0d want %0d", k, max_out[k], DEPTH); end
            if (done_cnt[k] != 1) begin n_fail++; $display("FAIL bp_done_count[%0d] got %0d want 1", k, done_cnt[k]); end
        end
    endtask

    task automatic test_zero_len();
        bit to;
        run_xfer(8'h44, 9'd0, 0, 0, -1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL zero_timeout got timeout want done"); end
        for (int k = 0; k < 2; k++) begin
            n_checks += 4;
            if (done_rel[k] != 1) begin n_fail++; $display("FAIL zero_done_cycle[%0d] got %0d want 1", k, done_rel[k]); end
            if (done_cnt[k] != 1) begin n_fail++; $display("FAIL zero_done_count[%0d] got %0d want 1", k, done_cnt[k]); end
            if (nb(k) != 0) begin n_fail++; $display("FAIL zero_beats[%0d] got %0d want 0", k, nb(k)); end
            if (busy_rise[k] != -1) begin n_fail++; $display("FAIL zero_busy[%0d] got rise at %0d want never", k, busy_rise[k]); end
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        run_xfer(8'h20, 9'd5, 0, 0, 3, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL busy_start_timeout got timeout want done"); end
        for (int k = 0; k < 2; k++) begin
            n_checks += 2;
            if (nb(k) != 5) begin n_fail++; $display("FAIL busy_start_count[%0d] got %0d want 5", k, nb(k)); end
            if (done_cnt[k] != 1) begin n_fail++; $display("FAIL busy_start_done[%0d] got %0d want 1", k, done_cnt[k]); end
            for (int i = 0; i < nb(k) && i < 5; i++) begin
                beat_t b = gb(k, i);
                n_checks++;
                if (b.data !== rom[8'h20 + i]) begin n_fail++; $display("FAIL busy_start_data[%0d] beat %0d got %h want %h", k, i, b.data, rom[8'h20 + i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit reached = 1'b0;
        beats0.delete();
        beats1.delete();
        sa = 8'h50;
        c0 = cyc;
        start = 1'b1;  start_addr = 8'h50;  length = 9'd12;  m_ready = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (nb(0) >= 3) begin reached = 1'b1; break; end
        end
        n_checks++;
        if (!reached) begin n_fail++; $display("FAIL rstmid_timeout got %0d beats want 3", nb(0)); end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks += 5;
            if (busy_w[k] !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busy[%0d] got %b want 0", k, busy_w[k]); end
            if (m_valid_w[k] !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid[%0d] got %b want 0", k, m_valid_w[k]); end
            if (m_last_w[k] !== 1'b0) begin n_fail++; $display("FAIL rstmid_last[%0d] got %b want 0", k, m_last_w[k]); end
            if (m_data_w[k] !== 16'h0) begin n_fail++; $display("FAIL rstmid_data[%0d] got %h want 0", k, m_data_w[k]); end
            if (rom_addr_w[k] !== 8'h0) begin n_fail++; $display("FAIL rstmid_addr[%0d] got %h want 0", k, rom_addr_w[k]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_xfer(8'h60, 9'd6, 0, 0, -1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL rstmid_rerun_timeout got timeout want done"); end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (nb(k) != 6) begin n_fail++; $display("FAIL rstmid_rerun_count[%0d] got %0d want 6", k, nb(k)); end
            for (int i = 0; i < nb(k) && i < 6; i++) begin
                beat_t b = gb(k, i);
                n_checks++;
                if (b.data !== rom[8'h60 + i]) begin n_fail++; $display("FAIL rstmid_rerun_data[%0d] beat %0d got %h want %h", k, i, b.data, rom[8'h60 + i]); end
            end
        end
    endtask

    task automatic test_loop();
        bit to;
        int passes;
`ifdef ROM_RD_LOOP_EN
        passes = 2;
`else
        passes = 1;
`endif
        run_xfer(8'h80, 9'd3, 4, 0, -1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL loop_timeout got timeout want done"); end
        for (int k = 0; k < 2; k++) begin
            int lat = k + 1;
            int total = 3 * passes;
            n_checks += 3;
            if (nb(k) != total) begin n_fail++; $display("FAIL loop_count[%0d] got %0d want %0d", k, nb(k), total); end
            if (done_cnt[k] != 1) begin n_fail++; $display("FAIL loop_done_count[%0d] got %0d want 1", k, done_cnt[k]); end
            if (done_rel[k] != 2 + lat + total) begin n_fail++; $display("FAIL loop_done_cycle[%0d] got %0d want %0d", k, done_rel[k], 2 + lat + total); end
            for (int i = 0; i < nb(k) && i < total; i++) begin
                beat_t b = gb(k, i);
                n_checks += 3;
                if (b.data !== rom[8'h80 + (i % 3)]) begin n_fail++; $display("FAIL loop_data[%0d] beat %0d got %h want %h", k, i, b.data, rom[8'h80 + (i % 3)]); end
                if (b.last !== ((i % 3) == 2)) begin n_fail++; $display("FAIL loop_last[%0d] beat %0d got %b want %b", k, i, b.last, ((i % 3) == 2)); end
                if (b.rel != 2 + lat + i) begin n_fail++; $display("FAIL loop_cycle[%0d] beat %0d got %0d want %0d", k, i, b.rel, 2 + lat + i); end
            end
        end
    endtask

    task automatic test_random();
        bit to;
        for (int r = 0; r < 5; r++) begin
            logic [7:0] a = 8'($urandom);
            int n = $urandom_range(1, 24);
            run_xfer(a, 9'(n), 0, 2, -1, to);
            n_checks++;
            if (to) begin n_fail++; $display("FAIL rand%0d_timeout got timeout want done", r); end
            for (int k = 0; k < 2; k++) begin
                n_checks += 4;
                if (nb(k) != n) begin n_fail++; $display("FAIL rand%0d_count[%0d] got %0d want %0d", r, k, nb(k), n); end
                if (done_cnt[k] != 1) begin n_fail++; $display("FAIL rand%0d_done[%0d] got %0d want 1", r, k, done_cnt[k]); end
                if (stall_viol[k] != 0) begin n_fail++; $display("FAIL rand%0d_stall[%0d] got %0d want 0", r, k, stall_viol[k]); end
                if (max_out[k] > DEPTH) begin n_fail++; $display("FAIL rand%0d_outstanding[%0d] got %0d want <=%0d", r, k, max_out[k], DEPTH); end
                for (int i = 0; i < nb(k) && i < n; i++) begin
                    logic [7:0] ad = 8'(a + i);
                    beat_t b = gb(k, i);
                    n_checks += 2;
                    if (b.data !== rom[ad]) begin n_fail++; $display("FAIL rand%0d_data[%0d] beat %0d got %h want %h", r, k, i, b.data, rom[ad]); end
                    if (b.last !== (i == n - 1)) begin n_fail++; $display("FAIL rand%0d_last[%0d] beat %0d got %b want %b", r, k, i, b.last, (i == n - 1)); end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_start_ignored();
        test_reset_mid();
        test_loop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
